// File: rtl/reg_write_arbiter_pkg.sv
// Shared field widths, requester identifiers and defaults for the
// two-requester register write arbiter with per-bank locking.
package reg_write_arbiter_pkg;

    localparam int BANK_W          = 2;
    localparam int REG_W           = 2;
    localparam int ADDR_W          = BANK_W + REG_W;
    localparam int DATA_W          = 8;
    localparam int NUM_BANKS       = 4;
    localparam int CNT_W           = 8;
    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [REG_W-1:0] TOP_REG = 2'd3;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:REG_W];
    endfunction

    // Writing the top register of a bank completes (and unlocks) that bank.
    function automatic logic is_top_reg(input logic [ADDR_W-1:0] addr);
        return addr[REG_W-1:0] == TOP_REG;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester and register-array signals of the write arbiter; the arbiter
// uses the slave modport, the requester/array side the master modport.
interface reg_write_arbiter_if;
    import reg_write_arbiter_pkg::*;

    logic                 req0;
    logic                 req1;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic [DATA_W-1:0]    data0;
    logic [DATA_W-1:0]    data1;
    logic                 ack0;
    logic                 ack1;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_BANKS-1:0] bank_event;
    logic [NUM_BANKS-1:0] lock_flags;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  ack0, ack1, wr_en, wr_addr, wr_data, bank_event, lock_flags
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output ack0, ack1, wr_en, wr_addr, wr_data, bank_event, lock_flags
    );

endinterface

// File: rtl/reg_write_arbiter_bank_lock.sv
// Lock state for one register bank: owner, valid flag and an idle counter
// that forcibly releases a lock left untouched for TIMEOUT cycles.
module bank_lock
    import reg_write_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    grant,
    input  req_id_t grant_id,
    input  logic    grant_top,
    output logic    locked,
    output req_id_t owner
);

    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] idle_cnt;

    // A grant only reaches this bank when it is free or owned by the grantee,
    // and it takes priority over a timeout expiring in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            owner    <= REQ0;
            idle_cnt <= '0;
        end else if (grant) begin
            idle_cnt <= '0;
            if (grant_top) begin
                locked <= 1'b0;
            end else begin
                locked <= 1'b1;
                owner  <= grant_id;
            end
        end else if (locked) begin
            if (idle_cnt == LAST_IDLE) begin
                locked   <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one register write per cycle from two
// requesters, with per-bank locks that keep a bank's writes atomic.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    reg_write_arbiter_if.slave  bus
);

    logic [NUM_BANKS-1:0] locked;
    req_id_t              owner [NUM_BANKS];

    logic [BANK_W-1:0]    bank0_p0;
    logic [BANK_W-1:0]    bank1_p0;
    logic                 elig0_p0;
    logic                 elig1_p0;
    logic                 vld_p0;
    req_id_t              gnt_id_p0;
    logic [ADDR_W-1:0]    gnt_addr_p0;
    logic [DATA_W-1:0]    gnt_data_p0;
    logic [BANK_W-1:0]    gnt_bank_p0;
    logic                 gnt_top_p0;
    logic [NUM_BANKS-1:0] bank_gnt_p0;

    req_id_t              rr_ptr;
    logic                 vld_p1;
    logic [1:0]           ack_p1;
    logic [ADDR_W-1:0]    addr_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [NUM_BANKS-1:0] event_p1;

    // Stage p0: eligibility and grant selection from the current lock state
    assign bank0_p0 = bank_of(bus.addr0);
    assign bank1_p0 = bank_of(bus.addr1);

    assign elig0_p0 = bus.req0 && !ack_p1[0] &&
                      (!locked[bank0_p0] || owner[bank0_p0] == REQ0);
    assign elig1_p0 = bus.req1 && !ack_p1[1] &&
                      (!locked[bank1_p0] || owner[bank1_p0] == REQ1);

    assign vld_p0 = elig0_p0 || elig1_p0;

    always_comb begin
        gnt_id_p0 = REQ0;
        if (elig0_p0 && elig1_p0) begin
            gnt_id_p0 = rr_ptr;
        end else if (elig1_p0) begin
            gnt_id_p0 = REQ1;
        end
    end

    assign gnt_addr_p0 = (gnt_id_p0 == REQ1) ? bus.addr1 : bus.addr0;
    assign gnt_data_p0 = (gnt_id_p0 == REQ1) ? bus.data1 : bus.data0;
    assign gnt_bank_p0 = bank_of(gnt_addr_p0);
    assign gnt_top_p0  = is_top_reg(gnt_addr_p0);

    always_comb begin
        bank_gnt_p0              = '0;
        bank_gnt_p0[gnt_bank_p0] = vld_p0;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_lock #(
            .TIMEOUT (TIMEOUT)
        ) u_lock (
            .clk       (clk),
            .rst       (rst),
            .grant     (bank_gnt_p0[b]),
            .grant_id  (gnt_id_p0),
            .grant_top (gnt_top_p0),
            .locked    (locked[b]),
            .owner     (owner[b])
        );
    end

    // Stage p1: registered write strobe, acknowledge and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            ack_p1   <= '0;
            event_p1 <= '0;
            addr_p1  <= '0;
            data_p1  <= '0;
            rr_ptr   <= REQ0;
        end else begin
            vld_p1   <= vld_p0;
            ack_p1   <= {vld_p0 && gnt_id_p0 == REQ1, vld_p0 && gnt_id_p0 == REQ0};
            event_p1 <= bank_gnt_p0 & {NUM_BANKS{gnt_top_p0}};
            if (vld_p0) begin
                addr_p1 <= gnt_addr_p0;
                data_p1 <= gnt_data_p0;
                rr_ptr  <= (gnt_id_p0 == REQ0) ? REQ1 : REQ0;
            end
        end
    end

    assign bus.wr_en      = vld_p1;
    assign bus.ack0       = ack_p1[0];
    assign bus.ack1       = ack_p1[1];
    assign bus.wr_addr    = addr_p1;
    assign bus.wr_data    = data_p1;
    assign bus.bank_event = event_p1;
    assign bus.lock_flags = locked;

endmodule
